rv32i_regfile: RTL and testbench

//  Architectural integer register file (x0..x31) of the 5-stage RV32I pipeline; the write port is driven
//  by the writeback stage (RegDst/RegWrData/RegWrEn) and the two read ports are driven by decode.

---
 rtl/rv32i_regfile_pkg.sv | 18 +
 rtl/rv32i_regfile_scoreboard.sv | 45 ++++
 rtl/rv32i_regfile.sv | 78 +++++++
 tb/tb_rv32i_regfile.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_regfile_pkg.sv
// Shared definitions for the RV32I integer register file and its load-use scoreboard.
package rv32i_regfile_pkg;

  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = $clog2(NREGS);

  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xword_t;

  // True when a retiring writeback targets the given index (x0 writes never retire).
  function automatic logic wb_hits(input logic wr_en, input reg_idx_t dst, input reg_idx_t addr);
    return wr_en && (dst == addr) && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/rv32i_regfile_scoreboard.sv
// Per-register pending-load scoreboard: a bit is set when decode issues a load and
// cleared when writeback retires that register or the pipeline is flushed.
module rv32i_regfile_scoreboard
  import rv32i_regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_dst,
  input  logic                 issue_load,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 pipe_stall,
  input  logic                 pipe_flush,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy
);

  logic [NREGS-1:0] busy;
  logic             issue_ok;

  assign issue_ok = issue_load && !pipe_stall && !pipe_flush && (issue_rd != REG_ZERO);

  // Busy-bit update: reset, then set (wins over a same-cycle retire), then clear, then flush.
  // NOTE: state registers use non-blocking assignments so every bit sees pre-edge values.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (reset || r == 0) begin
        busy[r] <= 1'b0;
      end else if (issue_ok && issue_rd == REG_IDX_W'(r)) begin
        busy[r] <= 1'b1;
      end else if (wr_en && wr_dst == REG_IDX_W'(r)) begin
        busy[r] <= 1'b0;
      end else if (pipe_flush) begin
        busy[r] <= 1'b0;
      end
    end
  end

  // A retiring write to the same register resolves the hazard this cycle, matching the data bypass.
  assign rs1_busy = busy[rs1_addr] && !wb_hits(wr_en, wr_dst, rs1_addr);
  assign rs2_busy = busy[rs2_addr] && !wb_hits(wr_en, wr_dst, rs2_addr);

endmodule

// File: rtl/rv32i_regfile.sv
// Architectural register file x0..x31 with two bypassed decode read ports, a raw
// debug read port and a pending-load scoreboard for load-use hazard detection.
module rv32i_regfile
  import rv32i_regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_RegWrEn,
  input  logic [REG_IDX_W-1:0] i_RegDst,
  input  logic [XLEN-1:0]      i_RegWrData,
  input  logic [REG_IDX_W-1:0] i_Rs1Addr,
  input  logic [REG_IDX_W-1:0] i_Rs2Addr,
  output logic [XLEN-1:0]      o_Rs1Data,
  output logic [XLEN-1:0]      o_Rs2Data,
  input  logic                 i_IssueLoad,
  input  logic [REG_IDX_W-1:0] i_IssueRd,
  input  logic                 i_pipe_stall,
  input  logic                 i_pipe_flush,
  output logic                 o_Rs1Busy,
  output logic                 o_Rs2Busy,
  input  logic [REG_IDX_W-1:0] i_DbgAddr,
  output logic [XLEN-1:0]      o_DbgData
);

  xword_t regs [NREGS];

  // Register storage: synchronous clear of every entry, writeback retires regardless of stall.
  // NOTE: storage is a flop array precisely because it must be cleared on reset; a RAM could not be.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (i_RegWrEn && i_RegDst != REG_ZERO) begin
      regs[i_RegDst] <= i_RegWrData;
    end
  end

  // Read port 1: x0 hardwired, else same-cycle writeback bypass, else stored value.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_Rs1Data = regs[i_Rs1Addr];
    if (i_Rs1Addr == REG_ZERO) begin
      o_Rs1Data = '0;
    end else if (wb_hits(i_RegWrEn, i_RegDst, i_Rs1Addr)) begin
      o_Rs1Data = i_RegWrData;
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    o_Rs2Data = regs[i_Rs2Addr];
    if (i_Rs2Addr == REG_ZERO) begin
      o_Rs2Data = '0;
    end else if (wb_hits(i_RegWrEn, i_RegDst, i_Rs2Addr)) begin
      o_Rs2Data = i_RegWrData;
    end
  end

  // Debug view shows architectural state only; x0 is never written so it reads zero.
  assign o_DbgData = regs[i_DbgAddr];

  rv32i_regfile_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (i_RegWrEn),
    .wr_dst     (i_RegDst),
    .issue_load (i_IssueLoad),
    .issue_rd   (i_IssueRd),
    .pipe_stall (i_pipe_stall),
    .pipe_flush (i_pipe_flush),
    .rs1_addr   (i_Rs1Addr),
    .rs2_addr   (i_Rs2Addr),
    .rs1_busy   (o_Rs1Busy),
    .rs2_busy   (o_Rs2Busy)
  );

endmodule

// File: tb/tb_rv32i_regfile.sv
// Directed bench for rv32i_regfile: expectations are queued when a step is driven
// and popped against DUT outputs a little after the falling edge.
module tb_rv32i_regfile;
  import rv32i_regfile_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_RegWrEn;
  logic [4:0]      i_RegDst;
  logic [XLEN-1:0] i_RegWrData;
  logic [4:0]      i_Rs1Addr, i_Rs2Addr, i_IssueRd, i_DbgAddr;
  logic [XLEN-1:0] o_Rs1Data, o_Rs2Data, o_DbgData;
  logic            i_IssueLoad, i_pipe_stall, i_pipe_flush;
  logic            o_Rs1Busy, o_Rs2Busy;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  rv32i_regfile dut (
    .clk          (clk),
    .reset        (reset),
    .i_RegWrEn    (i_RegWrEn),
    .i_RegDst     (i_RegDst),
    .i_RegWrData  (i_RegWrData),
    .i_Rs1Addr    (i_Rs1Addr),
    .i_Rs2Addr    (i_Rs2Addr),
    .o_Rs1Data    (o_Rs1Data),
    .o_Rs2Data    (o_Rs2Data),
    .i_IssueLoad  (i_IssueLoad),
    .i_IssueRd    (i_IssueRd),
    .i_pipe_stall (i_pipe_stall),
    .i_pipe_flush (i_pipe_flush),
    .o_Rs1Busy    (o_Rs1Busy),
    .o_Rs2Busy    (o_Rs2Busy),
    .i_DbgAddr    (i_DbgAddr),
    .o_DbgData    (o_DbgData)
  );

  task automatic expect_val(input string tag, input logic [XLEN-1:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [XLEN-1:0] obs);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Begin a step: inputs change on the falling edge, outputs are sampled 2 ns later.
  task automatic step_begin();
    @(negedge clk);
    reset        = 1'b0;
    i_RegWrEn    = 1'b0;
    i_IssueLoad  = 1'b0;
    i_pipe_stall = 1'b0;
    i_pipe_flush = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset = 1'b1; i_RegWrEn = 1'b0; i_RegDst = '0; i_RegWrData = '0;
    i_Rs1Addr = '0; i_Rs2Addr = '0; i_IssueLoad = 1'b0; i_IssueRd = '0;
    i_pipe_stall = 1'b0; i_pipe_flush = 1'b0; i_DbgAddr = '0;
    @(negedge clk);
    @(negedge clk);

    // 1: every index reads zero and not busy after reset
    for (int i = 0; i < NREGS; i++) begin
      step_begin();
      i_Rs1Addr = 5'(i); i_Rs2Addr = 5'(i); i_DbgAddr = 5'(i);
      expect_val($sformatf("rst_rs1_x%0d", i), '0);
      expect_val($sformatf("rst_rs2_x%0d", i), '0);
      expect_val($sformatf("rst_dbg_x%0d", i), '0);
      expect_val($sformatf("rst_busy1_x%0d", i), '0);
      expect_val($sformatf("rst_busy2_x%0d", i), '0);
      settle();
      check(o_Rs1Data); check(o_Rs2Data); check(o_DbgData);
      check(32'(o_Rs1Busy)); check(32'(o_Rs2Busy));
    end

    // 2: write x5, read it back; writes to x0 are dropped
    step_begin();
    i_RegWrEn = 1'b1; i_RegDst = 5'd5; i_RegWrData = 32'hDEADBEEF; i_Rs1Addr = 5'd0;
    settle();
    step_begin();
    i_Rs1Addr = 5'd5; i_DbgAddr = 5'd5;
    expect_val("x5_rs1", 32'hDEADBEEF);
    expect_val("x5_dbg", 32'hDEADBEEF);
    settle();
    check(o_Rs1Data); check(o_DbgData);
    step_begin();
    i_RegWrEn = 1'b1; i_RegDst = 5'd0; i_RegWrData = 32'h1234; i_Rs1Addr = 5'd0;
    expect_val("x0_bypass_blocked", '0);
    settle();
    check(o_Rs1Data);
    step_begin();
    i_Rs1Addr = 5'd0; i_DbgAddr = 5'd0;
    expect_val("x0_rs1_after", '0);
    expect_val("x0_dbg_after", '0);
    settle();
    check(o_Rs1Data); check(o_DbgData);

    // 3: same-cycle bypass to both ports, debug still shows old state
    step_begin();
    i_RegWrEn = 1'b1; i_RegDst = 5'd7; i_RegWrData = 32'hA5A5A5A5;
    i_Rs1Addr = 5'd7; i_Rs2Addr = 5'd7; i_DbgAddr = 5'd7;
    expect_val("byp_rs1_x7", 32'hA5A5A5A5);
    expect_val("byp_rs2_x7", 32'hA5A5A5A5);
    expect_val("byp_dbg_x7_old", '0);
    settle();
    check(o_Rs1Data); check(o_Rs2Data); check(o_DbgData);
    step_begin();
    expect_val("x7_dbg_new", 32'hA5A5A5A5);
    expect_val("x7_rs1_new", 32'hA5A5A5A5);
    settle();
    check(o_DbgData); check(o_Rs1Data);

    // 4: load issue sets busy; stalled issue does not; writeback clears in-cycle
    step_begin();
    i_IssueLoad = 1'b1; i_IssueRd = 5'd9; i_Rs1Addr = 5'd9;
    expect_val("x9_busy_issue_cycle", '0);
    settle();
    check(32'(o_Rs1Busy));
    step_begin();
    i_Rs1Addr = 5'd9;
    expect_val("x9_busy_set", 32'd1);
    settle();
    check(32'(o_Rs1Busy));
    step_begin();
    i_IssueLoad = 1'b1; i_pipe_stall = 1'b1; i_IssueRd = 5'd12;
    settle();
    step_begin();
    i_Rs1Addr = 5'd12;
    expect_val("x12_busy_stalled", '0);
    settle();
    check(32'(o_Rs1Busy));
    step_begin();
    i_RegWrEn = 1'b1; i_RegDst = 5'd9; i_RegWrData = 32'h99; i_Rs1Addr = 5'd9; i_Rs2Addr = 5'd9;
    expect_val("x9_busy1_wb_cycle", '0);
    expect_val("x9_busy2_wb_cycle", '0);
    settle();
    check(32'(o_Rs1Busy)); check(32'(o_Rs2Busy));
    step_begin();
    i_Rs1Addr = 5'd9;
    expect_val("x9_busy_after_wb", '0);
    expect_val("x9_data_after_wb", 32'h99);
    settle();
    check(32'(o_Rs1Busy)); check(o_Rs1Data);

    // 5: set wins over same-cycle clear; flush clears all busy bits and blocks set
    step_begin();
    i_IssueLoad = 1'b1; i_IssueRd = 5'd3;
    i_RegWrEn = 1'b1; i_RegDst = 5'd3; i_RegWrData = 32'h33;
    settle();
    step_begin();
    i_IssueLoad = 1'b1; i_IssueRd = 5'd4; i_Rs1Addr = 5'd3;
    expect_val("x3_busy_set_wins", 32'd1);
    expect_val("x3_data", 32'h33);
    settle();
    check(32'(o_Rs1Busy)); check(o_Rs1Data);
    step_begin();
    i_Rs1Addr = 5'd3; i_Rs2Addr = 5'd4;
    expect_val("x3_busy_pre_flush", 32'd1);
    expect_val("x4_busy_pre_flush", 32'd1);
    settle();
    check(32'(o_Rs1Busy)); check(32'(o_Rs2Busy));
    step_begin();
    i_pipe_flush = 1'b1; i_IssueLoad = 1'b1; i_IssueRd = 5'd5;
    settle();
    step_begin();
    i_Rs1Addr = 5'd3; i_Rs2Addr = 5'd4;
    expect_val("x3_busy_flushed", '0);
    expect_val("x4_busy_flushed", '0);
    settle();
    check(32'(o_Rs1Busy)); check(32'(o_Rs2Busy));
    step_begin();
    i_Rs1Addr = 5'd5;
    expect_val("x5_busy_flush_blocks_set", '0);
    settle();
    check(32'(o_Rs1Busy));

    // 6: reset overrides state and simultaneous write/issue
    step_begin();
    i_RegWrEn = 1'b1; i_RegDst = 5'd10; i_RegWrData = 32'h55;
    i_IssueLoad = 1'b1; i_IssueRd = 5'd10;
    settle();
    step_begin();
    i_Rs1Addr = 5'd10;
    expect_val("x10_pre_reset", 32'h55);
    expect_val("x10_busy_pre_reset", 32'd1);
    settle();
    check(o_Rs1Data); check(32'(o_Rs1Busy));
    step_begin();
    reset = 1'b1;
    i_RegWrEn = 1'b1; i_RegDst = 5'd11; i_RegWrData = 32'h77;
    i_IssueLoad = 1'b1; i_IssueRd = 5'd12;
    settle();
    step_begin();
    i_Rs1Addr = 5'd10; i_Rs2Addr = 5'd11; i_DbgAddr = 5'd11;
    expect_val("x10_after_reset", '0);
    expect_val("x11_after_reset", '0);
    expect_val("x11_dbg_after_reset", '0);
    expect_val("x10_busy_after_reset", '0);
    settle();
    check(o_Rs1Data); check(o_Rs2Data); check(o_DbgData); check(32'(o_Rs1Busy));
    step_begin();
    i_Rs1Addr = 5'd12; i_DbgAddr = 5'd5;
    expect_val("x12_busy_after_reset", '0);
    expect_val("x5_dbg_after_reset", '0);
    settle();
    check(32'(o_Rs1Busy)); check(o_DbgData);

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
